// File: rtl/spi_target_regs.sv
// spi_target_regs
//   SPI mode-3 target for 40-bit datagrams {wr, addr[6:0], data[31:0]}.
//   Write frames update a register bank. Read frames set the read pointer,
//   and the addressed register is returned in the NEXT frame, after the
//   status byte.
//
//   Optional feature macro: SPI_TARGET_ERRCNT_EN
//     Adds err_count_out, a saturating count of frames discarded for having
//     the wrong bit count. Status bit 7 is then replaced by (err_count_out != 0).
//
// Ports
//   clk_in, reset_in           system clock, async active-high reset
//   sclk_in, cs_n_in, mosi_in  SPI pins (unsynchronised)
//   miso_out, miso_oe_out      SPI return data and its output enable
//   status_in[7:0]             status byte, sampled when a frame starts
//   frame_valid_out            one-cycle pulse per accepted 40-bit frame
//   frame_wr/addr/data_out     fields of the last accepted frame
//   regs_out                   flattened register bank, reg k at [k*32 +: 32]
//   err_count_out[7:0]         (SPI_TARGET_ERRCNT_EN only) discarded-frame count
//
// FSM states
//   state | meaning
//   IDLE  | waiting for the synchronised cs_n falling edge
//   SHIFT | frame selected, shifting on the synchronised sclk rising edges
//   DONE  | one cycle after the cs_n rise: commit the frame or discard it
module spi_target_regs #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     sclk_in,
  input  logic                     cs_n_in,
  input  logic                     mosi_in,
  output logic                     miso_out,
  output logic                     miso_oe_out,
  input  logic [7:0]               status_in,
  output logic                     frame_valid_out,
  output logic                     frame_wr_out,
  output logic [6:0]               frame_addr_out,
  output logic [31:0]              frame_data_out,
  output logic [NUM_REGS*32-1:0]   regs_out
`ifdef SPI_TARGET_ERRCNT_EN
  ,
  output logic [7:0]               err_count_out
`endif
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   start_pend;
  logic [5:0]             bit_cnt;
  logic [39:0]            rx_shift, tx_shift;
  logic [6:0]             rd_ptr;
  logic [31:0]            regs [NUM_REGS];
  logic [31:0]            rd_data;
  logic [7:0]             status_eff;

  logic sclk_s, cs_s, mosi_s, sclk_rise, cs_fall, cs_rise;
  logic rd_ok, wr_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  assign rd_ok = ({1'b0, rd_ptr} < NUM_REGS_B);
  assign wr_ok = ({1'b0, rx_shift[38:32]} < NUM_REGS_B);

  always_comb begin
    rd_data = '0;
    if (rd_ok) rd_data = regs[rd_ptr[AW-1:0]];
  end

`ifdef SPI_TARGET_ERRCNT_EN
  assign status_eff = {err_count_out != 8'd0, status_in[6:0]};
`else
  assign status_eff = status_in;
`endif

  assign miso_oe_out = (state == SHIFT);
  assign miso_out    = (state == SHIFT) & tx_shift[39];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[k*32 +: 32] = regs[k];
  end

  // Synchronisers reset to 0, so a cs_n pin that is still low when reset is
  // released looks like "already selected": no falling edge is seen until the
  // pin goes high and falls again. Rising edges of the synchronised signals
  // that come out of reset land in IDLE and are ignored.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= IDLE;
      start_pend      <= 1'b0;
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      rd_ptr          <= '0;
      frame_valid_out <= 1'b0;
      frame_wr_out    <= 1'b0;
      frame_addr_out  <= '0;
      frame_data_out  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
`ifdef SPI_TARGET_ERRCNT_EN
      err_count_out   <= '0;
`endif
    end else begin
      frame_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          // start_pend holds a cs_n fall that arrived while in DONE
          if (cs_fall || start_pend) begin
            state      <= SHIFT;
            start_pend <= 1'b0;
            bit_cnt    <= '0;
            tx_shift   <= {status_eff, rd_data};
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[38:0], mosi_s};
            tx_shift <= {tx_shift[38:0], 1'b0};
            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          end
          if (cs_rise) state <= DONE;
        end
        DONE: begin
          state      <= IDLE;
          start_pend <= cs_fall;
          if (bit_cnt == 6'd40) begin
            frame_valid_out <= 1'b1;
            frame_wr_out    <= rx_shift[39];
            frame_addr_out  <= rx_shift[38:32];
            frame_data_out  <= rx_shift[31:0];
            if (rx_shift[39]) begin
              if (wr_ok) regs[rx_shift[32+AW-1:32]] <= rx_shift[31:0];
            end else begin
              rd_ptr <= rx_shift[38:32];
            end
          end
`ifdef SPI_TARGET_ERRCNT_EN
          else if (err_count_out != 8'hFF) begin
            err_count_out <= err_count_out + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_regs.sv
module tb_spi_target_regs;

  logic         clk_in = 1'b0;
  logic         reset_in, sclk_in, cs_n_in, mosi_in;
  logic         miso_out, miso_oe_out;
  logic [7:0]   status_in;
  logic         frame_valid_out, frame_wr_out;
  logic [6:0]   frame_addr_out;
  logic [31:0]  frame_data_out;
  logic [511:0] regs_out;
`ifdef SPI_TARGET_ERRCNT_EN
  logic [7:0]   err_count_out;
`endif

  spi_target_regs #(.NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
    .mosi_in(mosi_in), .miso_out(miso_out), .miso_oe_out(miso_oe_out),
    .status_in(status_in), .frame_valid_out(frame_valid_out),
    .frame_wr_out(frame_wr_out), .frame_addr_out(frame_addr_out),
    .frame_data_out(frame_data_out), .regs_out(regs_out)
`ifdef SPI_TARGET_ERRCNT_EN
    , .err_count_out(err_count_out)
`endif
  );

  always #20 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [39:0] exp_q[$];
  logic [31:0] mreg [16];
  logic [6:0]  mptr;
  int          merr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 16; k++)
      check($sformatf("reg%0d", k), 64'(regs_out[k*32 +: 32]), 64'(mreg[k]));
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mreg[k] = '0;
    mptr = '0;
    merr = 0;
  endtask

  // Scoreboard monitor: every frame_valid pulse consumes one expected frame.
  always @(negedge clk_in) begin
    if (!reset_in && frame_valid_out) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %h expected none",
                 {frame_wr_out, frame_addr_out, frame_data_out});
      end else begin
        check("frame", 64'({frame_wr_out, frame_addr_out, frame_data_out}),
              64'(exp_q.pop_front()));
      end
    end
  end

  task automatic spi_frame(input logic [39:0] tx, input int nbits, input int gap,
                           input int rst_at, output logic [39:0] rx);
    rx = '0;
    cs_n_in = 1'b0;
    repeat (8) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b0;
      mosi_in = tx[39-i];
      repeat (4) @(negedge clk_in);
      rx = {rx[38:0], miso_out};
      sclk_in = 1'b1;
      repeat (4) @(negedge clk_in);
      if (i + 1 == rst_at) begin
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
      end
    end
    repeat (4) @(negedge clk_in);
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic do_frame(input logic [39:0] tx, input int nbits, input logic [7:0] st,
                          input int gap, input int rst_at);
    logic [39:0] rx, exp_rx;
    logic [7:0]  st_eff;
    logic [31:0] rd;
    status_in = st;
    st_eff = st;
`ifdef SPI_TARGET_ERRCNT_EN
    st_eff[7] = (merr != 0);
`endif
    rd = (mptr < 7'd16) ? mreg[mptr[3:0]] : 32'h0;
    exp_rx = {st_eff, rd};
    if (nbits == 40 && rst_at < 0) begin
      exp_q.push_back(tx);
      if (tx[39]) begin
        if (tx[38:32] < 7'd16) mreg[tx[35:32]] = tx[31:0];
      end else begin
        mptr = tx[38:32];
      end
    end
    spi_frame(tx, nbits, gap, rst_at, rx);
    if (rst_at >= 0) model_clear();
    else if (nbits == 40) check($sformatf("miso_%h", tx), 64'(rx), 64'(exp_rx));
    else if (merr < 255) merr++;
  endtask

  initial begin
    #4000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    reset_in = 1'b1; sclk_in = 1'b1; cs_n_in = 1'b1; mosi_in = 1'b0; status_in = '0;
    model_clear();
    repeat (5) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (5) @(negedge clk_in);

    check("rst_valid", 64'(frame_valid_out), 64'd0);
    check("rst_oe", 64'(miso_oe_out), 64'd0);
    check("rst_miso", 64'(miso_out), 64'd0);
    check("rst_frame", 64'({frame_wr_out, frame_addr_out, frame_data_out}), 64'd0);
    check_regs();

    // write
    do_frame(40'h80_DEADBEEF, 40, 8'hA5, 12, -1);
    check_regs();

    // pipelined read
    do_frame(40'h83_12345678, 40, 8'h11, 12, -1);
    do_frame(40'h03_00000000, 40, 8'h22, 12, -1);
    do_frame(40'h00_00000000, 40, 8'h3C, 12, -1);
    check_regs();

    // short frame: discarded, read pointer kept (next frame returns reg 0)
    do_frame(40'h85_FFFFFFFF, 39, 8'h5A, 12, -1);
    check_regs();
`ifdef SPI_TARGET_ERRCNT_EN
    check("err_count", 64'(err_count_out), 64'd1);
`endif
    do_frame(40'h04_00000000, 40, 8'h81, 12, -1);

    // out-of-range write then read of 0x7F
    do_frame(40'hFF_00000001, 40, 8'h00, 12, -1);
    check_regs();
    do_frame(40'h7F_00000000, 40, 8'h66, 12, -1);
    do_frame(40'h00_00000000, 40, 8'h77, 12, -1);

    // reset mid-frame
    p0 = pulse_cnt;
    do_frame(40'h86_CAFEF00D, 40, 8'h12, 12, 20);
    check("rst_mid_pulses", 64'(pulse_cnt - p0), 64'd0);
    check("rst_mid_frame", 64'({frame_wr_out, frame_addr_out, frame_data_out}), 64'd0);
    check_regs();
    do_frame(40'h86_CAFEF00D, 40, 8'h34, 12, -1);
    check_regs();

    // back-to-back
    p0 = pulse_cnt;
    do_frame(40'h81_11111111, 40, 8'h01, 8, -1);
    do_frame(40'h82_22222222, 40, 8'h02, 12, -1);
    check("b2b_pulses", 64'(pulse_cnt - p0), 64'd2);
    check_regs();

    repeat (20) @(negedge clk_in);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
